// File: rtl/imem_if.sv
// Control, byte-stream and instruction-memory signals of the loader.
// master drives requests and bytes; slave is the loader itself.
interface imem_if;
    logic        start;
    logic [5:0]  start_addr;
    logic [6:0]  word_count;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, start_addr, word_count, abort,
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  busy, done, err
    );

    modport slave (
        input  start, start_addr, word_count, abort,
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: assembles little-endian
// 32-bit words and writes them to consecutive word slots.
module imem_loader #(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 8
) (
    input  logic   clk,
    input  logic   rst,
    imem_if.slave  bus
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              count_ok;

    assign count_ok = (bus.word_count != '0) &&
                      (int'(bus.word_count) <= WORDS);

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        remaining_d = remaining_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && count_ok) begin
                    word_idx_d  = bus.start_addr;
                    remaining_d = bus.word_count;
                    byte_cnt_d  = '0;
                    err_d       = 1'b0;
                    state_d     = S_RECV;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end
            end
            S_RECV: begin
                if (bus.abort) begin
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (bus.in_valid && in_ready_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Memory-side outputs change only when a write issues.
                        mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                        mem_wdata_d = {bus.in_data, word_q[23:0]};
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    word_idx_d  = word_idx_q + IDX_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_RECV;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Decoding the next state keeps every output registered.
        mem_we_d   = (state_d == S_WRITE);
        in_ready_d = (state_d == S_RECV);
        busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            remaining_q <= remaining_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and done pulses are
// queued by the stimulus and consumed by a negedge monitor.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_if ifc ();

    imem_loader #(.WORDS(64), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        bit          is_done;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] wbuf[8];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_we = -100;
    int hs = 0;
    int exp_hs = 0;
    int gap_pct = 30;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!rst) begin
            if (ifc.in_valid && ifc.in_ready) hs++;
            if (ifc.mem_we) begin
                last_we = cyc;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             ifc.mem_addr, ifc.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(ifc.mem_addr), 32'(e.addr));
                    chk("write_data", ifc.mem_wdata, e.data);
                end
            end
            if (ifc.done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_after_write", 32'(cyc - last_we), 32'd1);
                    chk("busy_in_done", 32'(ifc.busy), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_in_ready"}, 32'(ifc.in_ready), 0);
        chk({nm, "_mem_we"}, 32'(ifc.mem_we), 0);
        chk({nm, "_mem_addr"}, 32'(ifc.mem_addr), 0);
        chk({nm, "_mem_wdata"}, ifc.mem_wdata, 0);
        chk({nm, "_busy"}, 32'(ifc.busy), 0);
        chk({nm, "_done"}, 32'(ifc.done), 0);
        chk({nm, "_err"}, 32'(ifc.err), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while ($urandom_range(0, 99) < gap_pct) begin
            ifc.in_valid = 1'b0;
            ifc.in_data  = 8'($urandom);
            tick();
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        while (!ifc.in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(ifc.in_ready), 1);
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((ifc.busy || ifc.done) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) chk("idle_timeout", 32'(ifc.busy), 0);
        tick();
    endtask

    task automatic pulse_start(input logic [5:0] sa, input logic [6:0] wc);
        ifc.start      = 1'b1;
        ifc.start_addr = sa;
        ifc.word_count = wc;
        tick();
        ifc.start      = 1'b0;
        ifc.start_addr = 6'($urandom);
        ifc.word_count = 7'($urandom);
    endtask

    task automatic session(input logic [5:0] sa, input int n,
                           input int ab_word, input int ab_byte);
        int t;
        pulse_start(sa, 7'(n));
        chk("start_clears_err", 32'(ifc.err), 0);
        chk("busy_after_start", 32'(ifc.busy), 1);
        for (int i = 0; i < n; i++) begin
            if (i == ab_word) begin
                for (int b = 0; b < ab_byte; b++) send_byte(wbuf[i][8*b +: 8]);
                exp_hs += ab_byte;
                t = 0;
                while (!ifc.in_ready && t < 20) begin
                    tick();
                    t++;
                end
                ifc.abort = 1'b1;
                tick();
                ifc.abort = 1'b0;
                break;
            end
            exp_q.push_back('{1'b0, 8'(((int'(sa) + i) % 64) * 4), wbuf[i]});
            for (int b = 0; b < 4; b++) begin
                send_byte(wbuf[i][8*b +: 8]);
                if (i == 0 && b == 1) pulse_start(6'($urandom), 7'd1);
            end
            exp_hs += 4;
        end
        if (ab_word >= n) exp_q.push_back('{1'b1, 8'd0, 32'd0});
        wait_idle();
        chk("err_after_session", 32'(ifc.err), 32'(ab_word < n));
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("handshakes", 32'(hs), 32'(exp_hs));
    endtask

    task automatic bad_start(input logic [6:0] wc);
        pulse_start(6'($urandom), wc);
        chk("bad_start_err", 32'(ifc.err), 1);
        chk("bad_start_busy", 32'(ifc.busy), 0);
        repeat (3) tick();
        chk("bad_start_idle", 32'(ifc.busy | ifc.in_ready | ifc.mem_we), 0);
    endtask

    initial begin
        int pat[7];
        int k;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        ifc.start      = 1'b0;
        ifc.start_addr = '0;
        ifc.word_count = '0;
        ifc.abort      = 1'b0;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        wbuf[0] = 32'h00100093;
        session(6'd1, 1, 99, 0);

        wbuf[0] = 32'h00007033;
        wbuf[1] = 32'h00200113;
        session(6'd63, 2, 99, 0);

        wbuf[0] = 32'h404404B3;
        pulse_start(6'd10, 7'd1);
        exp_q.push_back('{1'b0, 8'h28, wbuf[0]});
        exp_q.push_back('{1'b1, 8'd0, 32'd0});
        k = 0;
        foreach (pat[i]) begin
            ifc.in_valid = pat[i][0];
            ifc.in_data  = pat[i] != 0 ? wbuf[0][8*k +: 8] : 8'($urandom);
            tick();
            if (pat[i] != 0) k++;
        end
        ifc.in_valid = 1'b0;
        exp_hs += 4;
        wait_idle();
        chk("gap_handshakes", 32'(hs), 32'(exp_hs));
        chk("gap_queue_drained", 32'(exp_q.size()), 0);

        bad_start(7'd0);
        bad_start(7'd65);
        bad_start(7'($urandom_range(66, 127)));
        wbuf[0] = 32'h00000013;
        session(6'd5, 1, 99, 0);

        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        session(6'd20, 3, 1, 2);

        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        pulse_start(6'd7, 7'd2);
        for (int b = 0; b < 3; b++) send_byte(wbuf[0][8*b +: 8]);
        exp_hs += 3;
        ifc.in_valid = 1'b1;
        ifc.in_data  = wbuf[0][31:24];
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        rst = 1'b0;
        repeat (12) tick();
        ifc.in_valid = 1'b0;
        chk("rst_no_resume", 32'(ifc.busy | ifc.in_ready), 0);
        chk("rst_handshakes", 32'(hs), 32'(exp_hs));

        for (int it = 0; it < 30; it++) begin
            int n;
            int aw;
            n = $urandom_range(1, 6);
            aw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : 99;
            gap_pct = $urandom_range(0, 60);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            if ($urandom_range(0, 4) == 0) bad_start(7'($urandom_range(65, 127)));
            session(6'($urandom), n, aw, $urandom_range(0, 3));
            ifc.abort = 1'b1;
            tick();
            ifc.abort = 1'b0;
            chk("idle_abort_no_effect", 32'(ifc.busy | ifc.mem_we), 0);
        end

        repeat (5) tick();
        chk("final_queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
